// File: rtl/ysyx_23060208_xbar_rd.sv
// AXI read-channel crossbar: one master, CLINT and SoC slaves.
// One transaction outstanding; the target is latched in the FSM state.
module ysyx_23060208_xbar_rd #(
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
   parameter logic [31:0] CLINT_SIZE = 32'h0001_0000
) (
   input  logic                    clock,
   input  logic                    reset,

   input  logic [DATA_WIDTH-1:0]   m_araddr,
   input  logic                    m_arvalid,
   input  logic [3:0]              m_arid,
   input  logic [7:0]              m_arlen,
   input  logic [2:0]              m_arsize,
   input  logic [1:0]              m_arburst,
   output logic                    m_arready,
   output logic                    m_rvalid,
   output logic                    m_rlast,
   output logic [2*DATA_WIDTH-1:0] m_rdata,
   output logic [1:0]              m_rresp,
   output logic [3:0]              m_rid,
   input  logic                    m_rready,

   output logic [DATA_WIDTH-1:0]   clint_araddr,
   output logic [3:0]              clint_arid,
   output logic [7:0]              clint_arlen,
   output logic [2:0]              clint_arsize,
   output logic [1:0]              clint_arburst,
   output logic                    clint_arvalid,
   input  logic                    clint_arready,
   input  logic                    clint_rvalid,
   input  logic                    clint_rlast,
   input  logic [2*DATA_WIDTH-1:0] clint_rdata,
   input  logic [1:0]              clint_rresp,
   input  logic [3:0]              clint_rid,
   output logic                    clint_rready,

   output logic [DATA_WIDTH-1:0]   soc_araddr,
   output logic [3:0]              soc_arid,
   output logic [7:0]              soc_arlen,
   output logic [2:0]              soc_arsize,
   output logic [1:0]              soc_arburst,
   output logic                    soc_arvalid,
   input  logic                    soc_arready,
   input  logic                    soc_rvalid,
   input  logic                    soc_rlast,
   input  logic [2*DATA_WIDTH-1:0] soc_rdata,
   input  logic [1:0]              soc_rresp,
   input  logic [3:0]              soc_rid,
   output logic                    soc_rready
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] AR_CLINT = 3'd1;
   localparam logic [2:0] AR_SOC   = 3'd2;
   localparam logic [2:0] R_CLINT  = 3'd3;
   localparam logic [2:0] R_SOC    = 3'd4;

   localparam int AW = DATA_WIDTH;

   // One extra bit so BASE+SIZE at the top of the map cannot wrap.
   localparam logic [AW:0] WIN_LO = (AW+1)'(CLINT_BASE);
   localparam logic [AW:0] WIN_HI = WIN_LO + (AW+1)'(CLINT_SIZE);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       hit_clint;
   logic       st_ar_clint;
   logic       st_ar_soc;
   logic       st_r_clint;
   logic       st_r_soc;

   assign hit_clint = ({1'b0, m_araddr} >= WIN_LO)
                   && ({1'b0, m_araddr} <  WIN_HI);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (m_arvalid) begin
               state_nxt = hit_clint ? AR_CLINT : AR_SOC;
            end
         end
         AR_CLINT: begin
            if (clint_arready && m_arvalid) begin
               state_nxt = R_CLINT;
            end
         end
         AR_SOC: begin
            if (soc_arready && m_arvalid) begin
               state_nxt = R_SOC;
            end
         end
         R_CLINT: begin
            if (clint_rvalid && m_rready && clint_rlast) begin
               state_nxt = IDLE;
            end
         end
         R_SOC: begin
            if (soc_rvalid && m_rready && soc_rlast) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs stay quiet while reset is held.
   assign st_ar_clint = ~reset && (state == AR_CLINT);
   assign st_ar_soc   = ~reset && (state == AR_SOC);
   assign st_r_clint  = ~reset && (state == R_CLINT);
   assign st_r_soc    = ~reset && (state == R_SOC);

   assign clint_araddr  = m_araddr;
   assign clint_arid    = m_arid;
   assign clint_arlen   = m_arlen;
   assign clint_arsize  = m_arsize;
   assign clint_arburst = m_arburst;
   assign soc_araddr    = m_araddr;
   assign soc_arid      = m_arid;
   assign soc_arlen     = m_arlen;
   assign soc_arsize    = m_arsize;
   assign soc_arburst   = m_arburst;

   assign clint_arvalid = st_ar_clint;
   assign soc_arvalid   = st_ar_soc;
   assign m_arready     = (st_ar_clint && clint_arready)
                       || (st_ar_soc && soc_arready);

   assign clint_rready = st_r_clint && m_rready;
   assign soc_rready   = st_r_soc && m_rready;

   always_comb begin
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      m_rdata  = '0;
      m_rresp  = '0;
      m_rid    = '0;
      unique case (1'b1)
         st_r_clint: begin
            m_rvalid = clint_rvalid;
            m_rlast  = clint_rlast;
            m_rdata  = clint_rdata;
            m_rresp  = clint_rresp;
            m_rid    = clint_rid;
         end
         st_r_soc: begin
            m_rvalid = soc_rvalid;
            m_rlast  = soc_rlast;
            m_rdata  = soc_rdata;
            m_rresp  = soc_rresp;
            m_rid    = soc_rid;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/ysyx_23060208_xbar_rd.md
Name: ysyx_23060208_xbar_rd

Overview:
- AXI read-channel crossbar: one upstream master (LSU/IFU arbiter output), two downstream slaves: CLINT and SoC bus.
- Decodes each AR address and forwards the request to exactly one slave.
- Returns that slave's R beats to the master, ending on the last-beat handshake.
- One transaction outstanding; sits directly upstream of the CLINT.

Parameters:
- DATA_WIDTH, 32, address width; read data width is 2*DATA_WIDTH.
- CLINT_BASE, 32'h0200_0000, first CLINT byte address.
- CLINT_SIZE, 32'h0001_0000, CLINT window size in bytes (power of two).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- m_araddr  in  DATA_WIDTH  master read address
- m_arvalid  in  1  master AR valid
- m_arid, m_arlen, m_arsize, m_arburst  in  4/8/3/2  master AR payload
- m_arready  out  1  AR accepted
- m_rvalid, m_rlast  out  1/1  R valid, last beat
- m_rdata  out  2*DATA_WIDTH  read data
- m_rresp, m_rid  out  2/4  response, ID
- m_rready  in  1  master ready for R
- clint_araddr, clint_arid, clint_arlen, clint_arsize, clint_arburst  out  DATA_WIDTH/4/8/3/2  copies of m_ar* payload
- clint_arvalid  out  1  AR valid to CLINT
- clint_arready  in  1  CLINT AR ready
- clint_rvalid, clint_rlast, clint_rdata, clint_rresp, clint_rid  in  1/1/2*DATA_WIDTH/2/4  CLINT R channel
- clint_rready  out  1  R ready to CLINT
- soc_araddr, soc_arid, soc_arlen, soc_arsize, soc_arburst  out  same widths  copies of m_ar* payload
- soc_arvalid  out  1; soc_arready  in  1
- soc_rvalid, soc_rlast, soc_rdata, soc_rresp, soc_rid  in  same widths; soc_rready  out  1

Behaviour:
- Decode: hit_clint = (m_araddr >= CLINT_BASE) && (m_araddr < CLINT_BASE+CLINT_SIZE), 32-bit unsigned compare, no overflow wrap. Every other address goes to SoC.
- AR payload is driven combinationally to both slaves at all times. Only the arvalid line is gated.
- States: IDLE, AR_CLINT, AR_SOC, R_CLINT, R_SOC (registered).
- IDLE: on m_arvalid=1, enter AR_CLINT or AR_SOC by decode. All arvalid outputs are 0 and m_arready=0.
- AR_x: x_arvalid=1, m_arready=x_arready. On x_arready=1 with m_arvalid=1 (handshake), go to R_x the next cycle. The master holds m_araddr stable per AXI, so the latched target stays valid. Wait indefinitely otherwise.
- R_x: the m_r* outputs mirror x_r*, and x_rready=m_rready. The non-selected slave sees rready=0 and its R inputs are ignored. On x_rvalid & m_rready & x_rlast, go to IDLE. Non-last beats stay in R_x (burst support).
- Outside the matching state: m_rvalid=0, m_rlast=0, m_rdata=0, m_rresp=0, m_rid=0, and both rready=0.
- Minimum latency: request to CLINT AR handshake is 1 cycle after m_arvalid rises. The next request is accepted no earlier than 1 cycle after the last R handshake (IDLE bubble).
- A slave rvalid arriving while in AR_x is not forwarded until the state is R_x.
- Reset: state goes to IDLE on the cycle after reset is sampled. While reset is high and on that following cycle, all valid/ready outputs are 0.
- Reset mid-transaction abandons the transaction with no drain. Slaves are reset by the same signal.
- Unexpected rvalid from a non-selected slave is dropped (rready=0). Nothing is flagged.

Test Plan:
- Reset released, m_arvalid=0 -> all valid/ready outputs 0, m_r* outputs 0 for 5 cycles.
- m_araddr=32'h0200_BFF8, arid=4'h3, arlen=0 -> clint_arvalid=1, soc_arvalid=0. After the CLINT returns rdata=64'h1234, rlast=1, rid=3: m_rdata=64'h1234, m_rid=3, m_rlast=1, then back to IDLE.
- m_araddr=32'h8000_0000, arlen=3, INCR, m_rready toggling 1/0 -> only the SoC is selected. 4 beats forwarded in order, stall cycles respected, IDLE only after the 4th beat with rlast.
- Boundary addresses 32'h01FF_FFFC and 32'h0201_0000 -> SoC. 32'h0200_0000 and 32'h0200_FFFC -> CLINT.
- CLINT in R phase with m_rready=0 for 10 cycles -> m_rvalid held 1, data stable, no new AR accepted even though m_arvalid=1 with a new address.
- Reset asserted while in R_SOC with rvalid pending -> next cycle all outputs 0, state IDLE. A new CLINT read afterwards completes normally.
